imem_fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the CPU datapath: takes the datapath's 8-bit `PC` and returns the 16-bit `Instr` word the datapath decodes. It holds a small direct-mapped line store of fetched words and runs a req/ack handshake to instruction memory on a miss. `Stall` gates the PC register and suppresses register writes while no valid instruction is present.

---
 rtl/imem_fetch_unit_pkg.sv | 16 +
 rtl/imem_fetch_unit_if.sv | 25 ++
 rtl/imem_fetch_unit_line_store.sv | 49 ++++
 rtl/imem_fetch_unit.sv | 98 +++++++++
 tb/tb_imem_fetch_unit.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/imem_fetch_unit_pkg.sv
// Shared CPU definitions used by the instruction fetch stage.
// Fetch FSM states, bus widths and the bubble instruction.
package cpu_pkg;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 16;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    CHECK = 2'd0,
    REQ   = 2'd1,
    ERR   = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/imem_fetch_unit_if.sv
// Request/acknowledge bus between the fetch stage and instruction memory.
// The fetch stage is the master; instruction memory is the slave.
interface imem_fetch_unit_if;
  import cpu_pkg::*;

  logic               ImemReq;
  logic [ADDR_W-1:0]  ImemAddr;
  logic               ImemAck;
  logic [INSTR_W-1:0] ImemRData;

  modport master (
    output ImemReq,
    output ImemAddr,
    input  ImemAck,
    input  ImemRData
  );

  modport slave (
    input  ImemReq,
    input  ImemAddr,
    output ImemAck,
    output ImemRData
  );

endinterface

// File: rtl/imem_fetch_unit_line_store.sv
// Direct-mapped line store: valid/tag/data per line, one combinational read
// port, one write port, and a global valid clear that overrides the write.
module fetch_line_store
  import cpu_pkg::*;
#(
  parameter int LINES = 4,
  localparam int IDX_W = $clog2(LINES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr_i,
  input  logic               we_i,
  input  logic [IDX_W-1:0]   widx_i,
  input  logic [ADDR_W-1:0]  wtag_i,
  input  logic [INSTR_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]   ridx_i,
  output logic               rvalid_o,
  output logic [ADDR_W-1:0]  rtag_o,
  output logic [INSTR_W-1:0] rdata_o
);

  logic [LINES-1:0]   valid_q;
  logic [ADDR_W-1:0]  tag_q  [LINES];
  logic [INSTR_W-1:0] data_q [LINES];

  // Line storage; a clear coinciding with a write drops the write entirely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < LINES; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else if (clr_i) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[widx_i] <= 1'b1;
      tag_q[widx_i]   <= wtag_i;
      data_q[widx_i]  <= wdata_i;
    end else begin
      valid_q <= valid_q;
    end
  end

  assign rvalid_o = valid_q[ridx_i];
  assign rtag_o   = tag_q[ridx_i];
  assign rdata_o  = data_q[ridx_i];

endmodule

// File: rtl/imem_fetch_unit.sv
// Instruction fetch stage: zero-latency hit path from a direct-mapped line store,
// req/ack refill on a miss, and a sticky error if memory never acknowledges.
module imem_fetch_unit
  import cpu_pkg::*;
#(
  parameter int LINES       = 4,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  PC,
  input  logic               Flush,
  output logic [INSTR_W-1:0] Instr,
  output logic               InstrValid,
  output logic               Stall,
  output logic               FetchErr,
  imem_fetch_unit_if.master  imem
);

  localparam int IDX_W = $clog2(LINES);
  localparam logic [7:0] ACK_LIMIT = 8'(ACK_TIMEOUT);

  fetch_state_e       state_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [7:0]         cnt_q;

  logic               line_valid_s;
  logic [ADDR_W-1:0]  line_tag_s;
  logic [INSTR_W-1:0] line_data_s;
  logic               hit_s;
  logic               we_s;

  // Refill writes land at the captured address, never at the live PC.
  assign we_s = (state_q == REQ) && imem.ImemAck;

  fetch_line_store #(.LINES(LINES)) u_store (
    .clk      (clk),
    .rst_n    (reset),
    .clr_i    (Flush),
    .we_i     (we_s),
    .widx_i   (addr_q[2 +: IDX_W]),
    .wtag_i   (addr_q),
    .wdata_i  (imem.ImemRData),
    .ridx_i   (PC[2 +: IDX_W]),
    .rvalid_o (line_valid_s),
    .rtag_o   (line_tag_s),
    .rdata_o  (line_data_s)
  );

  assign hit_s = line_valid_s && (line_tag_s == PC) && !Flush && (state_q == CHECK);

  // Fetch FSM with refill address capture and ack timeout counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= CHECK;
      addr_q  <= '0;
      cnt_q   <= 8'd0;
    end else begin
      case (state_q)
        CHECK: begin
          if (!hit_s) begin
            addr_q  <= PC;
            cnt_q   <= 8'd0;
            state_q <= REQ;
          end else begin
            state_q <= CHECK;
          end
        end
        REQ: begin
          // An ack in the final permitted cycle still completes the refill.
          if (imem.ImemAck) begin
            state_q <= CHECK;
          end else if (cnt_q + 8'd1 == ACK_LIMIT) begin
            cnt_q   <= cnt_q + 8'd1;
            state_q <= ERR;
          end else begin
            cnt_q   <= cnt_q + 8'd1;
            state_q <= REQ;
          end
        end
        ERR: begin
          state_q <= ERR;
        end
        default: begin
          state_q <= ERR;
        end
      endcase
    end
  end

  assign imem.ImemReq  = (state_q == REQ);
  assign imem.ImemAddr = addr_q;
  assign FetchErr      = (state_q == ERR);
  assign InstrValid    = hit_s;
  assign Stall         = !hit_s;
  assign Instr         = hit_s ? line_data_s : NOP_INSTR;

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Directed bench for imem_fetch_unit: per-cycle vector table for hits, misses,
// conflicts and flushes, plus hand sequences for timeout and reset corners.
module tb_imem_fetch_unit;

  typedef struct {
    logic [7:0]  pc;
    logic        flush;
    logic        ack;
    logic [15:0] rdata;
    logic        exp_valid;
    logic [15:0] exp_instr;
    logic        exp_req;
    logic [7:0]  exp_addr;
  } vec_t;

  logic        clk;
  logic        reset;
  logic [7:0]  pc;
  logic        flush;
  logic [15:0] instr;
  logic        instr_valid;
  logic        stall;
  logic        fetch_err;

  int n_tests;
  int n_fail;
  int req_cycles;
  vec_t vecs[$];

  imem_fetch_unit_if bus ();

  imem_fetch_unit #(.LINES(4), .ACK_TIMEOUT(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .PC         (pc),
    .Flush      (flush),
    .Instr      (instr),
    .InstrValid (instr_valid),
    .Stall      (stall),
    .FetchErr   (fetch_err),
    .imem       (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] p, input logic f, input logic a,
                              input logic [15:0] rd, input logic ev, input logic [15:0] ei,
                              input logic er, input logic [7:0] ea);
    vec_t v;
    v.pc = p; v.flush = f; v.ack = a; v.rdata = rd;
    v.exp_valid = ev; v.exp_instr = ei; v.exp_req = er; v.exp_addr = ea;
    return v;
  endfunction

  task automatic chk_idle(input string tag, input logic exp_err);
    chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, "_stall"}, 32'(stall), 32'd1);
    chk({tag, "_req"}, 32'(bus.ImemReq), 32'd0);
    chk({tag, "_err"}, 32'(fetch_err), 32'(exp_err));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk_idle(tag, 1'b0);
    chk({tag, "_instr"}, 32'(instr), 32'h0000);
    chk({tag, "_addr"}, 32'(bus.ImemAddr), 32'h00);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b0;
    pc = 8'h00;
    flush = 1'b0;
    bus.ImemAck = 1'b0;
    bus.ImemRData = 16'h0000;

    //          pc     fl    ack   rdata     valid instr    req   addr
    vecs.push_back(mk(8'h00, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 8'h00)); // cold miss
    vecs.push_back(mk(8'h00, 1'b0, 1'b1, 16'hA5C3, 1'b0, 16'h0000, 1'b1, 8'h00));
    vecs.push_back(mk(8'h00, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hA5C3, 1'b0, 8'h00));
    vecs.push_back(mk(8'h04, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 8'h00)); // fill line 1
    vecs.push_back(mk(8'h04, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 8'h04));
    vecs.push_back(mk(8'h04, 1'b0, 1'b1, 16'h1234, 1'b0, 16'h0000, 1'b1, 8'h04));
    vecs.push_back(mk(8'h04, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h1234, 1'b0, 8'h00));
    vecs.push_back(mk(8'h00, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hA5C3, 1'b0, 8'h00)); // hit
    vecs.push_back(mk(8'h10, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 8'h00)); // conflict
    vecs.push_back(mk(8'h00, 1'b0, 1'b1, 16'hBEEF, 1'b0, 16'h0000, 1'b1, 8'h10)); // PC change ignored
    vecs.push_back(mk(8'h00, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 8'h00)); // evicted
    vecs.push_back(mk(8'h00, 1'b0, 1'b1, 16'hA5C3, 1'b0, 16'h0000, 1'b1, 8'h00));
    vecs.push_back(mk(8'h00, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hA5C3, 1'b0, 8'h00));
    vecs.push_back(mk(8'h04, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 8'h00)); // flush masks hit
    vecs.push_back(mk(8'h04, 1'b1, 1'b1, 16'h5555, 1'b0, 16'h0000, 1'b1, 8'h04)); // flush + ack
    vecs.push_back(mk(8'h04, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 8'h00)); // miss again
    vecs.push_back(mk(8'h04, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 8'h04)); // flush, no ack
    vecs.push_back(mk(8'h04, 1'b0, 1'b1, 16'h7777, 1'b0, 16'h0000, 1'b1, 8'h04));
    vecs.push_back(mk(8'h04, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h7777, 1'b0, 8'h00));
    vecs.push_back(mk(8'h00, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 8'h00)); // line 0 flushed
    vecs.push_back(mk(8'h00, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 8'h00));
    vecs.push_back(mk(8'h00, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 8'h00));
    vecs.push_back(mk(8'h00, 1'b0, 1'b1, 16'h0F0F, 1'b0, 16'h0000, 1'b1, 8'h00)); // ack in last cycle
    vecs.push_back(mk(8'h00, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0F0F, 1'b0, 8'h00));
    vecs.push_back(mk(8'h08, 1'b0, 1'b1, 16'hDEAD, 1'b0, 16'h0000, 1'b0, 8'h00)); // ack outside REQ

    // Reset values while reset is held.
    @(negedge clk);
    #1;
    chk_reset_vals("rst_hold");

    @(negedge clk);
    reset = 1'b1;
    foreach (vecs[i]) begin
      pc = vecs[i].pc;
      flush = vecs[i].flush;
      bus.ImemAck = vecs[i].ack;
      bus.ImemRData = vecs[i].rdata;
      #1;
      chk($sformatf("v%0d_valid", i), 32'(instr_valid), 32'(vecs[i].exp_valid));
      chk($sformatf("v%0d_stall", i), 32'(stall), 32'(!vecs[i].exp_valid));
      chk($sformatf("v%0d_req", i), 32'(bus.ImemReq), 32'(vecs[i].exp_req));
      chk($sformatf("v%0d_err", i), 32'(fetch_err), 32'd0);
      if (vecs[i].exp_valid)
        chk($sformatf("v%0d_instr", i), 32'(instr), 32'(vecs[i].exp_instr));
      if (vecs[i].exp_req)
        chk($sformatf("v%0d_addr", i), 32'(bus.ImemAddr), 32'(vecs[i].exp_addr));
      @(negedge clk);
    end

    // Timeout: request for 8'h08 is never acknowledged.
    pc = 8'h08;
    flush = 1'b0;
    bus.ImemAck = 1'b0;
    req_cycles = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (!bus.ImemReq) break;
      if (req_cycles == 0) chk("to_addr", 32'(bus.ImemAddr), 32'h08);
      req_cycles++;
      @(negedge clk);
    end
    chk("to_req_cycles", 32'(req_cycles), 32'd3);
    chk_idle("to_err0", 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      bus.ImemAck = 1'b1;
      bus.ImemRData = 16'h1111;
      #1;
      chk_idle($sformatf("to_err%0d", c + 1), 1'b1);
    end

    // Reset out of ERR clears the error and the line store.
    @(negedge clk);
    bus.ImemAck = 1'b0;
    reset = 1'b0;
    #1;
    chk_reset_vals("rst_err");
    @(negedge clk);
    reset = 1'b1;
    pc = 8'h00;
    #1;
    chk_idle("post_err_miss", 1'b0);
    @(negedge clk);
    #1;
    chk("post_err_req", 32'(bus.ImemReq), 32'd1);
    chk("post_err_addr", 32'(bus.ImemAddr), 32'h00);

    // Reset mid-REQ drops the request before the next edge.
    #2;
    reset = 1'b0;
    #1;
    chk_reset_vals("rst_midreq");
    @(negedge clk);
    reset = 1'b1;
    pc = 8'h20;
    #1;
    chk_idle("fresh_miss", 1'b0);
    @(negedge clk);
    bus.ImemAck = 1'b1;
    bus.ImemRData = 16'hCAFE;
    #1;
    chk("fresh_req", 32'(bus.ImemReq), 32'd1);
    chk("fresh_addr", 32'(bus.ImemAddr), 32'h20);
    @(negedge clk);
    bus.ImemAck = 1'b0;
    #1;
    chk("fresh_valid", 32'(instr_valid), 32'd1);
    chk("fresh_instr", 32'(instr), 32'hCAFE);
    chk("fresh_stall", 32'(stall), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
